entry_gate_ctrl: RTL
====================

ENTRY_GATE_CTRL -- requirements
Module: entry_gate_ctrl

Interface
REQ-001 SHALL have parameter CAPACITY, default 16, number of parking slots (1..255).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 4, consecutive high cycles of motion_in required to accept a car (>=1).
REQ-003 SHALL have parameter OPEN_CYC, default 50, minimum cycles gate stays open (>=1).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port motion_in  input  1  registered car-present level from entry motion sensor.
REQ-007 SHALL have port exit_pulse  input  1  one-cycle pulse per car leaving the lot.
REQ-008 SHALL have port gate_open  output  1  barrier open command, level.
REQ-009 SHALL have port car_admitted  output  1  one-cycle pulse per admitted car.
REQ-010 SHALL have port full  output  1  high when occupancy == CAPACITY.
REQ-011 SHALL have port occupancy  output  $clog2(CAPACITY+1)  cars currently parked.
REQ-012 SHALL have port stuck_alarm  output  1  gate held open abnormally long (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, DEBOUNCE, OPEN.
REQ-014 IDLE -> DEBOUNCE when motion_in=1 and full=0; motion_in while full SHALL be ignored, gate stays closed.
REQ-015 DEBOUNCE SHALL count consecutive cycles with motion_in=1; any motion_in=0 cycle -> IDLE, counter cleared.
REQ-016 DEBOUNCE -> OPEN on the cycle the count reaches DEBOUNCE_CYC; car_admitted SHALL pulse for exactly that transition cycle, occupancy increments on the same edge.
REQ-017 gate_open SHALL be 1 exactly while state is OPEN (registered, first high cycle = first OPEN cycle).
REQ-018 OPEN SHALL load timer with OPEN_CYC on entry, decrement to 0 and saturate.
REQ-019 OPEN -> IDLE only when timer==0 and motion_in==0; motion_in=1 at expiry SHALL hold gate open (safety) until it drops.
REQ-020 exit_pulse SHALL decrement occupancy when occupancy>0; at 0 it SHALL be ignored (no wrap).
REQ-021 Simultaneous admit and exit_pulse in one cycle SHALL leave occupancy unchanged.
REQ-022 occupancy SHALL never exceed CAPACITY; full SHALL be combinational from occupancy.
REQ-023 Becoming full during OPEN SHALL not close the gate early; only new admissions are blocked.

Reset
REQ-024 rst SHALL force state IDLE, gate_open=0, car_admitted=0, occupancy=0, full=0, stuck_alarm=0, all counters 0.
REQ-025 rst asserted mid-OPEN SHALL close gate immediately; occupancy is cleared, not restored.

Configuration
REQ-026 With macro GATE_STUCK_ALARM_EN defined, stuck_alarm SHALL assert when OPEN persists 4*OPEN_CYC cycles after entry, and deassert on leaving OPEN.
REQ-027 Without GATE_STUCK_ALARM_EN, stuck_alarm SHALL be tied 0 and the alarm counter SHALL not be synthesised; all other behaviour identical.

Structure
REQ-028 Shared package park_pkg SHALL hold the gate state enum (IDLE/DEBOUNCE/OPEN) and default parameter constants.
REQ-029 Debounce counter SHALL be sub-module level_debounce (inputs clk, rst, level_in, clear; output stable_hit).

Verification
REQ-030 motion_in high 3 cycles then low (DEBOUNCE_CYC=4) -> no car_admitted, gate_open stays 0, occupancy 0.
REQ-031 motion_in high 4 cycles then low -> one car_admitted pulse, occupancy 1, gate_open high 50 cycles then 0.
REQ-032 16 admissions then motion_in high -> full=1, gate never opens; one exit_pulse -> occupancy 15, next car admitted.
REQ-033 exit_pulse with occupancy 0 -> occupancy stays 0; exit_pulse coincident with admit at occupancy 5 -> stays 5.
REQ-034 motion_in held high 300 cycles after admission -> gate_open held; with GATE_STUCK_ALARM_EN stuck_alarm rises at cycle 200 of OPEN, without macro stays 0.
REQ-035 rst pulse during OPEN at occupancy 3 -> gate_open 0 and occupancy 0 asynchronously, FSM IDLE.

Source files
------------

// File: rtl/park_pkg.sv
// park_pkg -- shared definitions for the parking entry gate slice.
//   gate_state_e      : entry gate FSM state encoding (IDLE / DEBOUNCE / OPEN)
//   DEF_CAPACITY      : default number of parking slots
//   DEF_DEBOUNCE_CYC  : default consecutive motion cycles needed to accept a car
//   DEF_OPEN_CYC      : default minimum open time of the barrier in cycles
package park_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      OPEN     = 2'd2
   } gate_state_e;

   localparam int unsigned DEF_CAPACITY     = 16;
   localparam int unsigned DEF_DEBOUNCE_CYC = 4;
   localparam int unsigned DEF_OPEN_CYC     = 50;

endpackage

// File: rtl/level_debounce.sv
// level_debounce -- counts consecutive high cycles of a level input.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   level_in   : level being qualified
//   clear      : forces the count back to zero
//   stable_hit : high on the HIT_CYC-th consecutive high cycle of level_in
module level_debounce
   import park_pkg::*;
#(
   parameter int unsigned HIT_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic level_in,
   input  logic clear,
   output logic stable_hit
);

   localparam int unsigned CW = $clog2(HIT_CYC + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || !level_in) begin
         cnt_d = '0;
      end else if (cnt_q != CW'(HIT_CYC)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // cnt_q holds the number of earlier high cycles, so the current high
   // cycle is the HIT_CYC-th one when cnt_q == HIT_CYC-1
   assign stable_hit = level_in && !clear && (cnt_q == CW'(HIT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/entry_gate_ctrl.sv
// entry_gate_ctrl -- parking lot entry barrier controller with occupancy count.
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   motion_in    : registered car-present level from the entry sensor
//   exit_pulse   : one-cycle pulse per car leaving the lot
//   gate_open    : barrier open command (high exactly while in OPEN)
//   car_admitted : one-cycle pulse in the first OPEN cycle of each admission
//   full         : occupancy == CAPACITY
//   occupancy    : cars currently parked
//   stuck_alarm  : gate held open for 4*OPEN_CYC cycles
// Optional feature macro: GATE_STUCK_ALARM_EN (stuck-open alarm counter).
module entry_gate_ctrl
   import park_pkg::*;
#(
   parameter int unsigned CAPACITY     = DEF_CAPACITY,
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned OPEN_CYC     = DEF_OPEN_CYC
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            motion_in,
   input  logic                            exit_pulse,
   output logic                            gate_open,
   output logic                            car_admitted,
   output logic                            full,
   output logic [$clog2(CAPACITY+1)-1:0]   occupancy,
   output logic                            stuck_alarm
);

   localparam int unsigned OW = $clog2(CAPACITY + 1);
   localparam int unsigned TW = $clog2(OPEN_CYC + 1);

   gate_state_e   state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [OW-1:0] occ_q,   occ_d;
   logic          gate_q,  gate_d;
   logic          admit_q, admit_d;
   logic          admit;
   logic          stable_hit;
   logic          deb_clear;

   assign full         = (occ_q == OW'(CAPACITY));
   assign occupancy    = occ_q;
   assign gate_open    = gate_q;
   assign car_admitted = admit_q;

   // motion while full never starts a debounce run
   assign deb_clear = (state_q == OPEN) || full;

   level_debounce #(
      .HIT_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .level_in   (motion_in),
      .clear      (deb_clear),
      .stable_hit (stable_hit)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      admit   = 1'b0;
      case (state_q)
         IDLE: begin
            if (motion_in && !full) begin
               if (stable_hit) begin
                  state_d = OPEN;
                  admit   = 1'b1;
               end else begin
                  state_d = DEBOUNCE;
               end
            end
         end
         DEBOUNCE: begin
            if (!motion_in) begin
               state_d = IDLE;
            end else if (stable_hit) begin
               state_d = OPEN;
               admit   = 1'b1;
            end
         end
         OPEN: begin
            // timer counts remaining open cycles including the current one;
            // it expires in its last cycle, then saturates at 0 while motion holds
            if ((timer_q <= TW'(1)) && !motion_in) begin
               state_d = IDLE;
            end else if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (admit) begin
         timer_d = TW'(OPEN_CYC);
      end

      occ_d = occ_q;
      if (admit && !exit_pulse && (occ_q != OW'(CAPACITY))) begin
         occ_d = occ_q + 1'b1;
      end else if (!admit && exit_pulse && (occ_q != '0)) begin
         occ_d = occ_q - 1'b1;
      end

      gate_d  = (state_d == OPEN);
      admit_d = admit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         occ_q   <= '0;
         gate_q  <= 1'b0;
         admit_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         occ_q   <= occ_d;
         gate_q  <= gate_d;
         admit_q <= admit_d;
      end
   end

`ifdef GATE_STUCK_ALARM_EN
   localparam int unsigned ALARM_CYC = 4 * OPEN_CYC;
   localparam int unsigned AW        = $clog2(ALARM_CYC + 1);

   logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
   logic          stuck_q,     stuck_d;

   // alarm_cnt holds the 1-based index of the current OPEN cycle
   always_comb begin
      alarm_cnt_d = alarm_cnt_q;
      if (admit) begin
         alarm_cnt_d = AW'(1);
      end else if (state_d != OPEN) begin
         alarm_cnt_d = '0;
      end else if (alarm_cnt_q != AW'(ALARM_CYC)) begin
         alarm_cnt_d = alarm_cnt_q + 1'b1;
      end
      stuck_d = (state_d == OPEN) && (alarm_cnt_d == AW'(ALARM_CYC));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alarm_cnt_q <= '0;
         stuck_q     <= 1'b0;
      end else begin
         alarm_cnt_q <= alarm_cnt_d;
         stuck_q     <= stuck_d;
      end
   end

   assign stuck_alarm = stuck_q;
`else
   assign stuck_alarm = 1'b0;
`endif

endmodule
